// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// operation codes, default latencies and FSM states.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  localparam int MDU_CW = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit owning HI/LO.
// Results are computed at start and committed after a fixed latency.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_LAT,
  parameter int DIV_CYCLES  = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e r_state;
  mdu_state_e w_next;

  logic [MDU_CW-1:0] r_cnt;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;
  logic [31:0]       r_pend_hi;
  logic [31:0]       r_pend_lo;
  logic              r_pend_wr;

  logic              w_idle;
  logic              w_long_op;
  logic              w_last;
  logic [31:0]       w_res_hi;
  logic [31:0]       w_res_lo;
  logic              w_res_wr;
  logic [63:0]       w_prod_s;
  logic [63:0]       w_prod_u;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;

  assign w_idle = (r_state == S_IDLE);
  assign w_last = (r_cnt == MDU_CW'(1));
  assign w_long_op = (MDUOp == MDU_MULT) ||
                     (MDUOp == MDU_MULTU) ||
                     (MDUOp == MDU_DIV) ||
                     (MDUOp == MDU_DIVU);

  assign w_sa = A;
  assign w_sb = B;
  assign w_prod_s = $signed({{32{A[31]}}, A}) *
                    $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Result of the selected long op from the current operands
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b1;
    case (MDUOp)
      MDU_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      MDU_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      MDU_DIV: begin
        if (B == 32'd0) begin
          w_res_wr = 1'b0;
        end else if (A == 32'h8000_0000 &&
                     B == 32'hFFFF_FFFF) begin
          // Quotient overflows; MIPS yields the dividend
          w_res_lo = 32'h8000_0000;
          w_res_hi = 32'd0;
        end else begin
          w_res_lo = w_sa / w_sb;
          w_res_hi = w_sa % w_sb;
        end
      end
      MDU_DIVU: begin
        if (B == 32'd0) begin
          w_res_wr = 1'b0;
        end else begin
          w_res_lo = A / B;
          w_res_hi = A % B;
        end
      end
      default: w_res_wr = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && w_long_op) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (r_state == S_RUN);
  end

  // Counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else if (w_idle) begin
      if (start) begin
        case (MDUOp)
          MDU_MULT, MDU_MULTU: begin
            r_cnt     <= MDU_CW'(MULT_CYCLES);
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
          end
          MDU_DIV, MDU_DIVU: begin
            r_cnt     <= MDU_CW'(DIV_CYCLES);
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
          end
          MDU_MTHI: r_hi <= A;
          MDU_MTLO: r_lo <= A;
          default: ;
        endcase
      end
    end else begin
      r_cnt <= r_cnt - MDU_CW'(1);
      if (w_last && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, corner
// sequences and random ops against a reference model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests;
  int n_fail;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[11];

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op == MDU_MULT || op == MDU_MULTU) return 5;
    if (op == MDU_DIV || op == MDU_DIVU) return 10;
    return 0;
  endfunction

  // Architectural effect of one op on {HI,LO}
  function automatic logic [63:0] ref_op(
      input logic [2:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] hi,
      input logic [31:0] lo);
    int sa;
    int sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (op)
      MDU_MULT: begin
        q = longint'(sa) * longint'(sb);
        return q;
      end
      MDU_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      MDU_DIV: begin
        if (b == 0) return {hi, lo};
        q = longint'(sa) / longint'(sb);
        r = longint'(sa) % longint'(sb);
        return {r[31:0], q[31:0]};
      end
      MDU_DIVU: begin
        if (b == 0) return {hi, lo};
        return {a % b, a / b};
      end
      MDU_MTHI: return {a, lo};
      MDU_MTLO: return {hi, a};
      default:  return {hi, lo};
    endcase
  endfunction

  // Issue one op, count busy cycles, check stability and result
  task automatic run_op(input string nm,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input int ecyc);
    int n;
    logic stable;
    @(negedge clk);
    start = 1'b1;
    MDUOp = op;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    stable = 1'b1;
    while (busy && n < 60) begin
      n++;
      if (HI !== cur_hi || LO !== cur_lo) stable = 1'b0;
      @(negedge clk);
    end
    chk({nm, " cycles"}, n, ecyc);
    chk({nm, " stable"}, {31'd0, stable}, 32'd1);
    chk({nm, " HI"}, HI, ehi);
    chk({nm, " LO"}, LO, elo);
    cur_hi = ehi;
    cur_lo = elo;
  endtask

  initial begin
    logic [63:0] m;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int n;

    n_tests = 0;
    n_fail  = 0;
    start = 1'b0;
    MDUOp = MDU_NONE;
    A = 32'd0;
    B = 32'd0;
    reset = 1'b1;

    tbl[0]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    tbl[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,
                32'h0000_0001, 32'hFFFF_FFFE, 5};
    tbl[2]  = '{MDU_DIVU,  32'd7, 32'd2,
                32'd1, 32'd3, 10};
    tbl[3]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 32'h8000_0000, 10};
    tbl[5]  = '{MDU_MTHI,  32'h1234_5678, 32'd0,
                32'h1234_5678, 32'h8000_0000, 0};
    tbl[6]  = '{MDU_MTLO,  32'h9ABC_DEF0, 32'd0,
                32'h1234_5678, 32'h9ABC_DEF0, 0};
    tbl[7]  = '{MDU_DIV,   32'd5, 32'd0,
                32'h1234_5678, 32'h9ABC_DEF0, 10};
    tbl[8]  = '{MDU_DIVU,  32'd9, 32'd0,
                32'h1234_5678, 32'h9ABC_DEF0, 10};
    tbl[9]  = '{3'd7,      32'hDEAD_BEEF, 32'd3,
                32'h1234_5678, 32'h9ABC_DEF0, 0};
    tbl[10] = '{MDU_NONE,  32'hCAFE_F00D, 32'd3,
                32'h1234_5678, 32'h9ABC_DEF0, 0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op,
             tbl[i].a, tbl[i].b, tbl[i].hi,
             tbl[i].lo, tbl[i].cyc);
    end

    // MTLO during an in-flight MULT is ignored
    @(negedge clk);
    start = 1'b1;
    MDUOp = MDU_MULT;
    A = 32'd3;
    B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    MDUOp = MDU_MTLO;
    A = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("ovl LO busy", LO, cur_lo);
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("ovl HI", HI, 32'd0);
    chk("ovl LO", LO, 32'd12);
    cur_hi = 32'd0;
    cur_lo = 32'd12;

    // MTHI on the completing edge is ignored
    @(negedge clk);
    start = 1'b1;
    MDUOp = MDU_MULTU;
    A = 32'd5;
    B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("last busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    MDUOp = MDU_MTHI;
    A = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk("cmpl busy", {31'd0, busy}, 32'd0);
    chk("cmpl HI", HI, 32'd0);
    chk("cmpl LO", LO, 32'd30);
    @(negedge clk);
    chk("cmpl HI2", HI, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd30;

    // Reset in cycle 3 of a DIV aborts it
    run_op("pre-rst", MDU_MTHI, 32'h5555_AAAA, 32'd0,
           32'h5555_AAAA, 32'd30, 0);
    @(negedge clk);
    start = 1'b1;
    MDUOp = MDU_DIV;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    repeat (15) @(negedge clk);
    chk("rst late HI", HI, 32'd0);
    chk("rst late LO", LO, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    // Random ops against the reference model
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      m = ref_op(rop, ra, rb, cur_hi, cur_lo);
      run_op($sformatf("rnd%0d op%0d", k, rop), rop,
             ra, rb, m[63:32], m[31:0], lat(rop));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Sits beside the ALU and takes the same forwarded A/B operands.
- Owns the HI/LO architectural registers.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, plus MTHI/MTLO; exposes HI/LO for MFHI/MFLO, which the EX result mux selects alongside the ALU result.
- Drives busy to the hazard unit so D-stage HI/LO-touching instructions stall.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a MULT/MULTU start (must be >=1).
- DIV_CYCLES, 10, cycles busy stays high after a DIV/DIVU start (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is a valid MDU op (not bubble/flushed); sampled at the clk edge.
- MDUOp  input  3  operation select (codes in Defines.v).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  multi-cycle operation in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; at a clk edge with reset=1: HI=0, LO=0, busy=0, counter=0, pending results=0.
- Reset mid-operation aborts the operation. No commit happens, and HI/LO read 0 afterwards.
- States: IDLE, RUN.
- IDLE + start + MDUOp in {MULT, MULTU, DIV, DIVU}, at edge E0:
  - Compute the result from A/B as sampled at E0 and latch it into pending_hi/pending_lo. A/B may change afterwards without effect.
  - Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN; busy=1 after E0.
- RUN: counter decrements each edge. At the edge where counter is 1:
  - HI<=pending_hi, LO<=pending_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO are visible in the cycle busy first reads 0.
- IDLE + start + MTHI: HI<=A at that edge. LO unchanged, busy stays 0.
- IDLE + start + MTLO: LO<=A. HI unchanged, busy stays 0.
- start while busy=1: ignored entirely, with no restart and no MTHI/MTLO write. The hazard unit must prevent this case; the bench checks that it is ignored.
- start with an undefined MDUOp: no effect.
- start coincident with the completing edge: busy is still 1 on that edge, so the start is ignored.
- Arithmetic:
  - MULT: {HI,LO} = 64-bit signed A*B.
  - MULTU: 64-bit unsigned A*B.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU): still busy for DIV_CYCLES. At completion HI/LO keep their pre-start values; no write.
- HI/LO outputs are direct register outputs, with no combinational path from A/B.

Decomposition:
- Defines.v gets:
  - MDUOp codes: `MDU_NONE=0, `MDU_MULT, `MDU_MULTU, `MDU_DIV, `MDU_DIVU, `MDU_MTHI, `MDU_MTLO.
  - Default latency constants used by the top-level instantiation.
- Single flat module. Result computation is combinational at start and lives inside mdu; no sub-module is warranted.

Test Plan:
- MULT A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; values unchanged while busy.
- MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. DIVU A=7, B=2 -> HI=1, LO=3 after 10 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV by zero:
  - Setup: MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 (each 1 cycle, busy=0).
  - Stimulus: DIV A=5, B=0.
  - Response: busy 10 cycles, then HI=0x12345678, LO=0x9ABCDEF0.
- Overlap and reset:
  - During a MULT in flight, assert start with MTLO A=0x1 -> ignored; LO ends at the MULT result.
  - Assert reset in cycle 3 of a DIV -> next cycle busy=0, HI=0, LO=0, and no later commit.
